// File: rtl/trivium_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : trivium_stream_if
//  Purpose  : Control and keystream handshake bundle for trivium_stream.
//  Revision : 1.0  initial release
// ============================================================================
interface trivium_stream_if #(
    parameter int W = 64
);
    logic         start;
    logic [79:0]  key;
    logic [79:0]  iv;
    logic         busy;
    logic         ks_valid;
    logic         ks_ready;
    logic [W-1:0] ks_data;

    modport master (
        output start, key, iv, ks_ready,
        input  busy, ks_valid, ks_data
    );

    modport slave (
        input  start, key, iv, ks_ready,
        output busy, ks_valid, ks_data
    );
endinterface
`default_nettype wire

// File: rtl/trivium_stream.sv
`default_nettype none
// ============================================================================
//  Module   : trivium_stream
//  Purpose  : Trivium keystream generator, W rounds per clock, valid/ready out.
//  Revision : 1.0  initial release
// ============================================================================
module trivium_stream #(
    parameter int W           = 64,
    parameter int INIT_ROUNDS = 1152
) (
    input  wire logic       clk,
    input  wire logic       reset,
    trivium_stream_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int c_INIT_CYCLES = INIT_ROUNDS / W;
    localparam int c_CNT_W       = (c_INIT_CYCLES > 1) ? $clog2(c_INIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_INIT_CYCLES - 1);

    state_t               r_state;
    logic [287:0]         r_s;        // r_s[i-1] holds Trivium bit s(i)
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_valid;
    logic [W-1:0]         r_data;

    logic [287:0]         w_load;
    logic [287:0]         w_next;
    logic [W-1:0]         w_z;
    logic [288:0]         w_r;

    // Returns {z, next_state} for one standard Trivium round.
    function automatic logic [288:0] f_round(input logic [287:0] s);
        logic t1, t2, t3, z;
        t1 = s[65]  ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
        t2 = t2 ^ (s[174] & s[175]) ^ s[263];
        t3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    assign w_load = {3'b111, 108'd0, 4'd0, bus.iv, 13'd0, bus.key};

    always_comb begin
        w_next = r_s;
        w_z    = '0;
        w_r    = '0;
        for (int j = 0; j < W; j++) begin
            w_r    = f_round(w_next);
            w_z[j] = w_r[288];
            w_next = w_r[287:0];
        end
    end

    // start overrides every state, including a pending unconsumed word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (bus.start) begin
            r_state <= INIT;
            r_s     <= w_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_s <= w_next;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!r_valid || bus.ks_ready) begin
                        r_s     <= w_next;
                        r_data  <= w_z;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.ks_valid = r_valid;
    assign bus.ks_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_trivium_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trivium_stream
//  Purpose  : Directed bench for trivium_stream against a bit-serial model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trivium_stream;

    localparam logic [79:0] c_KEY_A = 80'h0f1e_2d3c_4b5a_6978_8796;
    localparam logic [79:0] c_IV_A  = 80'h1234_5678_9abc_def0_1357;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    trivium_stream_if #(.W(64)) if64 ();
    trivium_stream_if #(.W(8))  if8  ();
    trivium_stream_if #(.W(1))  if1  ();
    trivium_stream_if #(.W(64)) ifs  ();

    trivium_stream #(.W(64), .INIT_ROUNDS(1152)) u_dut64 (.clk(clk), .reset(reset), .bus(if64));
    trivium_stream #(.W(8),  .INIT_ROUNDS(1152)) u_dut8  (.clk(clk), .reset(reset), .bus(if8));
    trivium_stream #(.W(1),  .INIT_ROUNDS(1152)) u_dut1  (.clk(clk), .reset(reset), .bus(if1));
    trivium_stream #(.W(64), .INIT_ROUNDS(64))   u_duts  (.clk(clk), .reset(reset), .bus(ifs));

    int   n_tests = 0;
    int   n_fail  = 0;
    logic gold [0:2047];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference, 1-based state exactly as the algorithm is written.
    task automatic golden(input logic [79:0] k, input logic [79:0] v,
                          input int rounds, input int nbits);
        logic s [1:288];
        logic t1, t2, t3;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < rounds + nbits; r++) begin
            t1 = s[66]  ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            if (r >= rounds) gold[r - rounds] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91]  & s[92])  ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 93;  i >= 2;   i--) s[i] = s[i-1];
            s[1] = t3;
            for (int i = 177; i >= 95;  i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = t2;
        end
    endtask

    function automatic logic [63:0] gw(input int base, input int w);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < w; j++) r[j] = gold[base + j];
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int i64, i8, i1, cyc;
        {if64.start, if8.start, if1.start, ifs.start} = '0;
        {if64.ks_ready, if8.ks_ready, if1.ks_ready, ifs.ks_ready} = '0;
        if64.key = '0; if64.iv = '0; if8.key = '0; if8.iv = '0;
        if1.key  = '0; if1.iv  = '0; ifs.key = '0; ifs.iv = '0;

        // Reset is asynchronous: outputs clear before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst_busy",  64'(if64.busy),     64'd0);
        check("rst_valid", 64'(if64.ks_valid), 64'd0);
        check("rst_data",  if64.ks_data,       64'd0);
        check("rst_busy1", 64'(if1.busy),      64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Cold start, key=0 iv=0, continuous ready.
        golden(80'd0, 80'd0, 1152, 1024);
        if64.ks_ready = 1'b1;
        if64.start = 1'b1; tick(); if64.start = 1'b0;
        k = 0;
        while (if64.busy === 1'b1 && k < 100) begin k++; tick(); end
        check("A_busy_cycles", 64'(k), 64'd18);
        check("A_valid_at_run_entry", 64'(if64.ks_valid), 64'd0);
        tick();
        check("A_first_valid", 64'(if64.ks_valid), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("A_word%0d", i), if64.ks_data, gw(64 * i, 64));
            tick();
        end

        // Backpressure: word must hold while ready is low.
        if64.ks_ready = 1'b0;
        if64.start = 1'b1; tick(); if64.start = 1'b0;
        k = 0;
        while (if64.ks_valid !== 1'b1 && k < 100) begin k++; tick(); end
        check("B_valid_latency", 64'(k), 64'd19);
        check("B_word0", if64.ks_data, gw(0, 64));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("B_hold_valid%0d", i), 64'(if64.ks_valid), 64'd1);
            check($sformatf("B_hold_data%0d", i),  if64.ks_data, gw(0, 64));
        end
        if64.ks_ready = 1'b1;
        tick();
        check("B_word1", if64.ks_data, gw(64, 64));

        // Restart from RUN with start and ready together.
        golden(80'h1, 80'd0, 1152, 1024);
        if64.key = 80'h1;
        if64.start = 1'b1; tick(); if64.start = 1'b0;
        check("C_valid_dropped", 64'(if64.ks_valid), 64'd0);
        k = 0;
        while (if64.busy === 1'b1 && k < 100) begin k++; tick(); end
        check("C_busy_cycles", 64'(k), 64'd18);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("C_word%0d", i), if64.ks_data, gw(64 * i, 64));
            tick();
        end

        // Asynchronous reset mid-INIT, start ignored while held low.
        golden(80'd0, 80'd0, 1152, 1024);
        if64.key = 80'd0;
        if64.start = 1'b1; tick(); if64.start = 1'b0;
        repeat (5) tick();
        check("D_busy_before_reset", 64'(if64.busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("D_rst_busy",  64'(if64.busy),     64'd0);
        check("D_rst_valid", 64'(if64.ks_valid), 64'd0);
        check("D_rst_data",  if64.ks_data,       64'd0);
        tick();
        if64.start = 1'b1; tick(); if64.start = 1'b0;
        reset = 1'b1;
        tick();
        check("D_start_ignored", 64'(if64.busy), 64'd0);
        if64.start = 1'b1; tick(); if64.start = 1'b0;
        k = 0;
        while (if64.busy === 1'b1 && k < 100) begin k++; tick(); end
        check("D_busy_cycles", 64'(k), 64'd18);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("D_word%0d", i), if64.ks_data, gw(64 * i, 64));
            tick();
        end

        // Same key/iv across widths, irregular ready on the W=8 instance.
        golden(c_KEY_A, c_IV_A, 1152, 1024);
        if64.key = c_KEY_A; if64.iv = c_IV_A;
        if8.key  = c_KEY_A; if8.iv  = c_IV_A;
        if1.key  = c_KEY_A; if1.iv  = c_IV_A;
        if64.start = 1'b1; if8.start = 1'b1; if1.start = 1'b1;
        tick();
        if64.start = 1'b0; if8.start = 1'b0; if1.start = 1'b0;
        i64 = 0; i8 = 0; i1 = 0; cyc = 0;
        while ((i64 < 16 || i8 < 128 || i1 < 1024) && cyc < 5000) begin
            if64.ks_ready = (cyc % 2 == 0);
            if8.ks_ready  = ($urandom_range(0, 3) != 0);
            if1.ks_ready  = 1'b1;
            if (if64.ks_valid && if64.ks_ready && i64 < 16) begin
                check($sformatf("E_w64_%0d", i64), if64.ks_data, gw(64 * i64, 64));
                i64++;
            end
            if (if8.ks_valid && if8.ks_ready && i8 < 128) begin
                check($sformatf("E_w8_%0d", i8), 64'(if8.ks_data), gw(8 * i8, 8));
                i8++;
            end
            if (if1.ks_valid && if1.ks_ready && i1 < 1024) begin
                check($sformatf("E_w1_%0d", i1), 64'(if1.ks_data), gw(i1, 1));
                i1++;
            end
            tick();
            cyc++;
        end
        check("E_count64", 64'(i64), 64'd16);
        check("E_count8",  64'(i8),  64'd128);
        check("E_count1",  64'(i1),  64'd1024);

        // Shortened warm-up: one INIT cycle.
        golden(c_KEY_A, c_IV_A, 64, 512);
        ifs.key = c_KEY_A; ifs.iv = c_IV_A; ifs.ks_ready = 1'b1;
        ifs.start = 1'b1; tick(); ifs.start = 1'b0;
        k = 0;
        while (ifs.busy === 1'b1 && k < 100) begin k++; tick(); end
        check("F_busy_cycles", 64'(k), 64'd1);
        tick();
        check("F_first_valid", 64'(ifs.ks_valid), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("F_word%0d", i), ifs.ks_data, gw(64 * i, 64));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
